// File: rtl/mii_rx_deframer_if.sv
// mii_rx_deframer_if: MII receive pins plus the deframed byte stream.
// The deframer connects through the slave modport. The master modport is
// the view of whatever drives the MII pins and consumes the byte stream.
interface mii_rx_deframer_if;
  logic [3:0] rxd;
  logic       rx_dv;
  logic       rx_err;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_sop;
  logic       out_eop;
  logic       out_err;

  modport master (
    output rxd, rx_dv, rx_err,
    input  out_data, out_valid, out_sop, out_eop, out_err
  );

  modport slave (
    input  rxd, rx_dv, rx_err,
    output out_data, out_valid, out_sop, out_eop, out_err
  );
endinterface

// File: rtl/mii_rx_deframer.sv
// mii_rx_deframer: strips the preamble/SFD from an MII receive stream.
// It assembles nibbles into bytes (low nibble first) and forwards them with
// a one-byte delay, so that the final byte can carry eop and the frame verdict.
// Optional feature: define MII_RX_CRC_CHECK_EN to add an FCS (CRC-32) residue
// check to the frame verdict.
module mii_rx_deframer #(
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1518
) (
  input  logic                rx_clk,
  input  logic                rst,
  mii_rx_deframer_if.slave    mii,
  output logic [15:0]         frames_ok_cnt,
  output logic [15:0]         frames_err_cnt
);

  localparam int CNT_W = $clog2(MAX_FRAME_BYTES + 2);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_FRAME_BYTES + 1);
  localparam logic [CNT_W-1:0] LEN_MIN = CNT_W'(MIN_FRAME_BYTES);
  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(MAX_FRAME_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DROP     = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;

  logic [3:0]       low_nib_r;
  logic             nib_phase_r;   // 1: the low nibble is captured and the high nibble is due
  logic [7:0]       hold_data_r;
  logic             hold_vld_r;
  logic             sop_pend_r;    // no byte of this frame has been emitted yet
  logic             err_r;         // rx_err was seen during DATA
  logic [CNT_W-1:0] byte_cnt_r;

  logic [7:0]       out_data_r;
  logic             out_valid_r;
  logic             out_sop_r;
  logic             out_eop_r;
  logic             out_err_r;

  logic [7:0]       out_data_nxt_s;
  logic             out_valid_nxt_s;
  logic             out_sop_nxt_s;
  logic             out_eop_nxt_s;
  logic             out_err_nxt_s;

  logic             byte_done_s;
  logic             frame_end_s;
  logic             beat_s;
  logic             len_bad_s;
  logic             crc_bad_s;
  logic             frame_bad_s;
  logic             ok_inc_s;
  logic             err_inc_s;

`ifdef MII_RX_CRC_CHECK_EN
  logic [31:0]      crc_r;

  // Reflected CRC-32 (poly 0xEDB88320), one byte per call, no final inversion.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data_in);
    logic [31:0] c;
    c = crc_in ^ {24'd0, data_in};
    for (int b = 0; b < 8; b++) begin
      if (c[0]) begin
        c = (c >> 1) ^ 32'hEDB8_8320;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  // The shift-right register leaves the residue bit-reversed. Reverse it back
  // so that it compares against the familiar 0xC704DD7B magic value.
  function automatic logic [31:0] bit_rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  assign crc_bad_s = (bit_rev32(crc_r) != 32'hC704_DD7B);
`else
  assign crc_bad_s = 1'b0;
`endif

  assign byte_done_s = (state_r == ST_DATA) && mii.rx_dv && nib_phase_r;
  assign frame_end_s = (state_r == ST_DATA) && !mii.rx_dv;
  assign beat_s      = hold_vld_r && (byte_done_s || frame_end_s);
  assign len_bad_s   = (byte_cnt_r < LEN_MIN) || (byte_cnt_r > LEN_MAX);
  // A leftover low nibble (nib_phase_r) at end of frame is a dribble error.
  assign frame_bad_s = err_r || nib_phase_r || len_bad_s || crc_bad_s;
  // A frame with no complete byte emits nothing and counts as an error.
  assign ok_inc_s    = frame_end_s && hold_vld_r && !frame_bad_s;
  assign err_inc_s   = frame_end_s && !(hold_vld_r && !frame_bad_s);

  assign mii.out_data  = out_data_r;
  assign mii.out_valid = out_valid_r;
  assign mii.out_sop   = out_sop_r;
  assign mii.out_eop   = out_eop_r;
  assign mii.out_err   = out_err_r;

  // State register.
  always_ff @(posedge rx_clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: preamble/SFD detection and end-of-carrier handling.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!mii.rx_dv) begin
          state_nxt_s = ST_IDLE;
        end else if (mii.rxd == 4'h5) begin
          state_nxt_s = ST_PREAMBLE;
        end else begin
          state_nxt_s = ST_DROP;
        end
      end
      ST_PREAMBLE: begin
        if (!mii.rx_dv) begin
          state_nxt_s = ST_IDLE;
        end else if (mii.rxd == 4'h5) begin
          state_nxt_s = ST_PREAMBLE;
        end else if (mii.rxd == 4'hD) begin
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_DROP;
        end
      end
      ST_DATA: begin
        if (!mii.rx_dv) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_DROP: begin
        if (!mii.rx_dv) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DROP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode: emit the held byte; eop and the verdict travel with the last one.
  always_comb begin
    out_valid_nxt_s = 1'b0;
    out_sop_nxt_s   = 1'b0;
    out_eop_nxt_s   = 1'b0;
    out_err_nxt_s   = 1'b0;
    out_data_nxt_s  = out_data_r;
    if (beat_s) begin
      out_valid_nxt_s = 1'b1;
      out_data_nxt_s  = hold_data_r;
      out_sop_nxt_s   = sop_pend_r;
      out_eop_nxt_s   = frame_end_s;
      out_err_nxt_s   = frame_end_s && frame_bad_s;
    end else begin
      out_valid_nxt_s = 1'b0;
      out_data_nxt_s  = out_data_r;
    end
  end

  // Datapath: nibble assembly, one-byte hold, length/error tracking, outputs, counters.
  always_ff @(posedge rx_clk) begin
    if (rst) begin
      low_nib_r      <= 4'd0;
      nib_phase_r    <= 1'b0;
      hold_data_r    <= 8'd0;
      hold_vld_r     <= 1'b0;
      sop_pend_r     <= 1'b1;
      err_r          <= 1'b0;
      byte_cnt_r     <= '0;
      out_data_r     <= 8'd0;
      out_valid_r    <= 1'b0;
      out_sop_r      <= 1'b0;
      out_eop_r      <= 1'b0;
      out_err_r      <= 1'b0;
      frames_ok_cnt  <= 16'd0;
      frames_err_cnt <= 16'd0;
`ifdef MII_RX_CRC_CHECK_EN
      crc_r          <= 32'hFFFF_FFFF;
`endif
    end else begin
      out_data_r  <= out_data_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      out_sop_r   <= out_sop_nxt_s;
      out_eop_r   <= out_eop_nxt_s;
      out_err_r   <= out_err_nxt_s;

      if (state_r != ST_DATA) begin
        // Outside DATA: prepare a clean frame context for the next SFD.
        nib_phase_r <= 1'b0;
        hold_vld_r  <= 1'b0;
        sop_pend_r  <= 1'b1;
        err_r       <= 1'b0;
        byte_cnt_r  <= '0;
`ifdef MII_RX_CRC_CHECK_EN
        crc_r       <= 32'hFFFF_FFFF;
`endif
      end else if (mii.rx_dv) begin
        err_r <= err_r | mii.rx_err;
        if (!nib_phase_r) begin
          low_nib_r   <= mii.rxd;
          nib_phase_r <= 1'b1;
        end else begin
          nib_phase_r <= 1'b0;
          hold_data_r <= {mii.rxd, low_nib_r};
          hold_vld_r  <= 1'b1;
          if (hold_vld_r) begin
            sop_pend_r <= 1'b0;
          end
          if (byte_cnt_r != CNT_SAT) begin
            byte_cnt_r <= byte_cnt_r + CNT_W'(1);
          end
`ifdef MII_RX_CRC_CHECK_EN
          crc_r <= crc32_byte(crc_r, {mii.rxd, low_nib_r});
`endif
        end
      end

      if (ok_inc_s) begin
        frames_ok_cnt <= frames_ok_cnt + 16'd1;
      end
      if (err_inc_s) begin
        frames_err_cnt <= frames_err_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mii_rx_deframer.sv
// tb_mii_rx_deframer: random and directed MII bursts are checked against a
// burst-level reference model. The model parses each rx_dv burst as a whole:
// preamble, SFD, data nibbles, error flags and FCS.
module tb_mii_rx_deframer;
  localparam int MIN_B = 64;
  localparam int MAX_B = 1518;

  logic        rx_clk = 1'b0;
  logic        rst    = 1'b1;
  logic [15:0] frames_ok_cnt;
  logic [15:0] frames_err_cnt;

  mii_rx_deframer_if mii_bus ();

  mii_rx_deframer #(.MIN_FRAME_BYTES(MIN_B), .MAX_FRAME_BYTES(MAX_B)) dut (
    .rx_clk         (rx_clk),
    .rst            (rst),
    .mii            (mii_bus),
    .frames_ok_cnt  (frames_ok_cnt),
    .frames_err_cnt (frames_err_cnt)
  );

  always #5 rx_clk = ~rx_clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  int          got_eop_cyc = -1;
  int          exp_eop_cyc = 0;
  bit          exp_eop;
  logic [3:0]  b_nib[$];
  bit          b_err[$];
  logic [10:0] exp_q[$];
  logic [10:0] got_q[$];
  logic [15:0] m_ok  = 16'd0;
  logic [15:0] m_err = 16'd0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in;
    for (int b = 0; b < 8; b++) begin
      c = ((c[0] ^ d[b]) != 1'b0) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  always @(posedge rx_clk) cyc <= cyc + 1;

  // Beat monitor: samples 1 time unit after the active edge. err is masked off non-eop beats.
  always @(posedge rx_clk) begin
    #1;
    if (mii_bus.out_valid === 1'b1) begin
      got_q.push_back({mii_bus.out_sop, mii_bus.out_eop, mii_bus.out_eop & mii_bus.out_err, mii_bus.out_data});
      if (mii_bus.out_eop === 1'b1) got_eop_cyc = cyc;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic put(input logic [3:0] n, input bit e);
    b_nib.push_back(n);
    b_err.push_back(e);
  endtask

  // Frame builder: 15 preamble nibbles, SFD, then nbytes bytes (last 4 = FCS when nbytes >= 4).
  task automatic build(input int nbytes, input bit good_fcs);
    logic [7:0]  by[$];
    logic [31:0] c;
    b_nib.delete();
    b_err.delete();
    repeat (15) put(4'h5, 1'b0);
    put(4'hD, 1'b0);
    if (nbytes >= 4) begin
      c = 32'hFFFF_FFFF;
      for (int k = 0; k < nbytes - 4; k++) begin
        by.push_back(8'($urandom));
        c = crc_byte(c, by[k]);
      end
      c = ~c;
      by.push_back(c[7:0]);
      by.push_back(c[15:8]);
      by.push_back(c[23:16]);
      by.push_back(c[31:24]);
      if (!good_fcs) by[nbytes-2] = by[nbytes-2] ^ 8'h10;
    end else begin
      for (int k = 0; k < nbytes; k++) by.push_back(8'($urandom));
    end
    foreach (by[k]) begin
      put(by[k][3:0], 1'b0);
      put(by[k][7:4], 1'b0);
    end
  endtask

  // Reference model for nibbles [lo,hi). at_eop=0 means the segment was cut off by reset.
  task automatic model_seg(input int lo, input int hi, input bit at_eop);
    int          i;
    int          d;
    int          nb;
    bit          bad;
    logic [7:0]  bytes[$];
    logic [31:0] c;
    i = lo;
    if (i >= hi) return;
    if (b_nib[i] != 4'h5) return;
    while (i < hi && b_nib[i] == 4'h5) i++;
    if (i >= hi) return;
    if (b_nib[i] != 4'hD) return;
    i++;
    d  = hi - i;
    nb = d / 2;
    bad = ((d % 2) != 0) || (nb < MIN_B) || (nb > MAX_B);
    for (int j = i; j < hi; j++) if (b_err[j]) bad = 1'b1;
    for (int k = 0; k < nb; k++) bytes.push_back({b_nib[i+2*k+1], b_nib[i+2*k]});
`ifdef MII_RX_CRC_CHECK_EN
    if (nb < 4) begin
      bad = 1'b1;
    end else begin
      c = 32'hFFFF_FFFF;
      for (int k = 0; k < nb - 4; k++) c = crc_byte(c, bytes[k]);
      if (~c != {bytes[nb-1], bytes[nb-2], bytes[nb-3], bytes[nb-4]}) bad = 1'b1;
    end
`else
    c = 32'd0;
`endif
    if (!at_eop) begin
      for (int k = 0; k < nb - 1; k++) exp_q.push_back({(k == 0), 1'b0, 1'b0, bytes[k]});
    end else if (nb == 0) begin
      m_err = m_err + 16'd1;
    end else begin
      for (int k = 0; k < nb; k++)
        exp_q.push_back({(k == 0), (k == nb - 1), ((k == nb - 1) && bad), bytes[k]});
      exp_eop = 1'b1;
      if (bad) m_err = m_err + 16'd1;
      else     m_ok  = m_ok + 16'd1;
    end
  endtask

  // Drive the current burst with rx_dv high, then a single rx_dv-low cycle, and check the result.
  task automatic send(input string tag, input int rst_at);
    int n;
    n = b_nib.size();
    exp_q.delete();
    got_q.delete();
    exp_eop = 1'b0;
    got_eop_cyc = -1;
    if (rst_at >= 0) begin
      model_seg(0, rst_at, 1'b0);
      m_ok  = 16'd0;
      m_err = 16'd0;
      model_seg(rst_at + 1, n, 1'b1);
    end else begin
      model_seg(0, n, 1'b1);
    end
    for (int j = 0; j < n; j++) begin
      @(negedge rx_clk);
      mii_bus.rxd    = b_nib[j];
      mii_bus.rx_dv  = 1'b1;
      mii_bus.rx_err = b_err[j];
      rst            = (j == rst_at);
      if (j == rst_at) begin
        @(posedge rx_clk);
        #2;
        check({tag, "_rst_valid"}, 32'(mii_bus.out_valid), 32'd0);
        check({tag, "_rst_okcnt"}, 32'(frames_ok_cnt), 32'd0);
        check({tag, "_rst_errcnt"}, 32'(frames_err_cnt), 32'd0);
      end
    end
    @(negedge rx_clk);
    mii_bus.rx_dv  = 1'b0;
    mii_bus.rxd    = 4'h0;
    mii_bus.rx_err = 1'b0;
    rst            = 1'b0;
    exp_eop_cyc    = cyc + 1;
    @(posedge rx_clk);
    #2;
    check({tag, "_nbeats"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check($sformatf("%s_beat%0d", tag, k), 32'(got_q[k]), 32'(exp_q[k]));
    if (exp_eop) check({tag, "_eop_cycle"}, 32'(got_eop_cyc), 32'(exp_eop_cyc));
    check({tag, "_okcnt"}, 32'(frames_ok_cnt), 32'(m_ok));
    check({tag, "_errcnt"}, 32'(frames_err_cnt), 32'(m_err));
  endtask

  task automatic do_reset();
    @(negedge rx_clk);
    rst = 1'b1;
    mii_bus.rx_dv = 1'b0;
    repeat (2) @(posedge rx_clk);
    #2;
    check("reset_out", {mii_bus.out_data, mii_bus.out_valid, mii_bus.out_sop,
                        mii_bus.out_eop, mii_bus.out_err}, 32'd0);
    check("reset_cnt", {frames_ok_cnt, frames_err_cnt}, 32'd0);
    m_ok  = 16'd0;
    m_err = 16'd0;
    @(negedge rx_clk);
    rst = 1'b0;
  endtask

  initial begin
    mii_bus.rxd    = 4'h0;
    mii_bus.rx_dv  = 1'b0;
    mii_bus.rx_err = 1'b0;
    do_reset();

    // Good 64-byte frame
    build(64, 1'b1);
    send("good64", -1);
    // rx_err on DATA nibble 20
    do_reset();
    build(64, 1'b1);
    b_err[16 + 19] = 1'b1;
    send("rxerr", -1);
    // 129 DATA nibbles (dribble)
    do_reset();
    build(64, 1'b1);
    put(4'hA, 1'b0);
    send("dribble", -1);
    // Garbage burst, then a good frame after a 1-cycle gap
    do_reset();
    b_nib.delete();
    b_err.delete();
    repeat (40) put(4'h3, 1'b0);
    send("garbage", -1);
    build(64, 1'b1);
    send("after_garbage", -1);
    // Reset at byte 30 of a 100-byte frame, then a good frame
    build(100, 1'b1);
    send("midreset", 16 + 60);
    build(64, 1'b1);
    send("post_reset", -1);
    // Flipped FCS bit
    build(64, 1'b0);
    send("badfcs", -1);
    // Length boundaries
    build(1, 1'b1);
    send("len1", -1);
    build(0, 1'b1);
    send("len0", -1);
    build(63, 1'b1);
    send("len63", -1);
    build(MAX_B, 1'b1);
    send("lenmax", -1);
    build(MAX_B + 1, 1'b1);
    send("lenmax1", -1);
    build(MAX_B + 7, 1'b1);
    send("lensat", -1);
    // Preamble aborted by rx_dv low, then preamble broken by a bad nibble
    b_nib.delete();
    b_err.delete();
    put(4'h5, 1'b0);
    put(4'h5, 1'b0);
    send("pre_abort", -1);
    b_nib.delete();
    b_err.delete();
    repeat (4) put(4'h5, 1'b0);
    repeat (10) put(4'hD, 1'b0);
    b_nib[4] = 4'h7;
    send("pre_bad", -1);
    // Randomized frames
    for (int r = 0; r < 24; r++) begin
      build($urandom_range(60, 80), ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 3) == 0) b_err[$urandom_range(16, b_nib.size() - 1)] = 1'b1;
      if ($urandom_range(0, 4) == 0) put(4'($urandom), 1'b0);
      if ($urandom_range(0, 5) == 0) b_nib[$urandom_range(0, 15)] = 4'($urandom);
      send($sformatf("rnd%0d", r), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mii_rx_deframer.md
MII_RX_DEFRAMER -- requirements
Module: mii_rx_deframer

Interface
REQ-001 The block SHALL have parameter MIN_FRAME_BYTES, default 64, meaning the minimum legal frame length in bytes, counted from destination address through FCS.
REQ-002 The block SHALL have parameter MAX_FRAME_BYTES, default 1518, meaning the maximum legal frame length in bytes, counted from destination address through FCS.
REQ-003 rx_clk  input  1  receive clock; the only clock; all logic on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 rxd  input  4  MII receive nibble.
REQ-006 rx_dv  input  1  MII receive data valid.
REQ-007 rx_err  input  1  MII receive error.
REQ-008 out_data  output  8  received byte.
REQ-009 out_valid  output  1  out_data valid; one-cycle pulse per byte; no backpressure.
REQ-010 out_sop  output  1  first byte of frame; qualified by out_valid.
REQ-011 out_eop  output  1  last byte of frame; qualified by out_valid.
REQ-012 out_err  output  1  frame error; valid only with out_eop.
REQ-013 frames_ok_cnt  output  16  count of frames ending with out_err=0; wraps 0xFFFF->0.
REQ-014 frames_err_cnt  output  16  count of errored frames; wraps 0xFFFF->0.

Function
REQ-015 The block SHALL implement the states IDLE, PREAMBLE, DATA and DROP.
REQ-016 IDLE transitions: rx_dv=1 and rxd=0x5 -> PREAMBLE; rx_dv=1 with any other rxd -> DROP; rx_dv=0 -> stay in IDLE.
REQ-017 PREAMBLE transitions: rxd=0x5 -> stay; rxd=0xD -> DATA; any other rxd -> DROP; rx_dv=0 -> IDLE; no output in this state.
REQ-018 DROP SHALL produce no output, no counter change and no error, and SHALL return to IDLE on the first rx_dv=0 sample.
REQ-019 In DATA, nibbles SHALL be assembled low nibble first; a byte completes when its high nibble is sampled.
REQ-020 Each completed byte SHALL be held one byte deep and emitted with out_valid=1 for exactly one cycle, starting at the edge that completes the next byte.
REQ-021 When rx_dv is first sampled 0 in DATA, the held byte SHALL be emitted on that edge with out_eop=1, and the state SHALL become IDLE.
REQ-022 out_sop SHALL be 1 on the first emitted byte of a frame; a 1-byte frame SHALL carry out_sop=1 and out_eop=1 on the same beat.
REQ-023 Any rx_err=1 sample in DATA SHALL force out_err=1 at eop; bytes continue to be forwarded.
REQ-024 An odd nibble count at end of frame (dribble) SHALL discard the trailing nibble and force out_err=1.
REQ-025 A frame length below MIN_FRAME_BYTES or above MAX_FRAME_BYTES SHALL force out_err=1.
REQ-026 The byte counter SHALL saturate at MAX_FRAME_BYTES+1 and SHALL never wrap; bytes beyond the maximum are still forwarded.
REQ-027 DATA ending with zero complete bytes SHALL emit no beats and SHALL increment frames_err_cnt.
REQ-028 At each eop exactly one of frames_ok_cnt or frames_err_cnt SHALL increment, on the same edge as the eop beat.
REQ-029 rx_dv low for a single cycle between frames SHALL be sufficient: the eop beat of frame N and IDLE detection of frame N+1 SHALL proceed without loss.

Reset
REQ-030 rst=1 SHALL force state to IDLE and set out_data=0, out_valid=0, out_sop=0, out_eop=0, out_err=0 and both counters to 0.
REQ-031 rst=1 SHALL discard any held byte and any partial frame; no eop SHALL follow a mid-frame reset.
REQ-032 After rst deasserts with rx_dv=1 mid-frame, the block SHALL enter DROP (unless rxd=0x5) and SHALL wait for rx_dv=0.

Configuration
REQ-033 With macro MII_RX_CRC_CHECK_EN defined, the block SHALL compute CRC-32 (IEEE 802.3, reflected, init 0xFFFFFFFF) over all DATA bytes including the FCS, and SHALL force out_err=1 at eop when the residue is not 0xC704DD7B.
REQ-034 With MII_RX_CRC_CHECK_EN undefined, no CRC logic SHALL exist, and the FCS SHALL not affect out_err.

Verification
REQ-035 15x 0x5 then 0xD, then a 64-byte frame with valid FCS -> 64 beats, sop on beat 1, eop on beat 64, out_err=0, frames_ok_cnt=1.
REQ-036 The same frame with rx_err=1 on DATA nibble 20 -> 64 beats, out_err=1 at eop, frames_err_cnt=1.
REQ-037 129 DATA nibbles -> 64 beats, out_err=1, trailing nibble dropped.
REQ-038 rx_dv=1 with rxd=0x3 first for 40 cycles, then a good 64-byte frame after a 1-cycle gap -> no beats for the first burst; second frame ok, frames_ok_cnt=1.
REQ-039 rst pulsed at byte 30 of a 100-byte frame -> out_valid=0 from the next edge, counters=0, no eop; the next good frame passes.
REQ-040 One FCS bit flipped in a 64-byte frame -> out_err=1 with MII_RX_CRC_CHECK_EN defined; out_err=0 without it.
